// File: rtl/vdac_sample_driver.sv
// vdac_sample_driver: buffers signed samples in a small FIFO and releases one
// sample per programmable sample-rate tick to the vdac data/enable inputs.
// An FSM sequences the IDLE, PRIME and RUN phases. An empty FIFO on a tick
// outputs midscale (code 0). Dropping run_i flushes the FIFO.
module vdac_sample_driver #(
    parameter  int BITWIDTH   = 6,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DIV_WIDTH  = 16,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [BITWIDTH-1:0]  sample_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    input  logic                 run_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic [LVL_W-1:0]     fifo_level_o,
    output logic                 underrun_o,
    output logic                 tick_o,
    output logic [BITWIDTH-1:0]  dac_data_o,
    output logic                 dac_enable_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q;
    logic [DIV_WIDTH-1:0] count_q;
    logic [BITWIDTH-1:0]  data_q;
    logic                 enable_q;
    logic                 tick_q;
    logic                 underrun_q;
    logic                 ready_en_q;

    logic [BITWIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic full;
    logic empty;
    logic primed;
    logic stop;
    logic tick_now;
    logic push;
    logic pop;
    logic [BITWIDTH-1:0] head;

    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign primed   = (level_q >= LVL_W'(FIFO_DEPTH / 2));
    assign head     = mem_q[rd_ptr_q];

    // Leaving RUN flushes the FIFO and overrides any push seen in the same cycle.
    assign stop     = (state_q == ST_RUN) && !run_i;

    // The >= compare lets a lowered div_i take effect at once instead of wrapping.
    assign tick_now = (state_q == ST_RUN) && run_i && (count_q >= div_i);

    // An empty FIFO underruns on a tick even if a push arrives in the same cycle.
    assign pop      = tick_now && !empty;

    // Ready is held low until the first clock after reset release.
    assign sample_ready_o = ready_en_q && !full;
    assign push           = sample_valid_i && sample_ready_o && !stop;

    // ------------------------------------------------------------------
    // FIFO pointer and level next-state
    // ------------------------------------------------------------------
    // Compute the next FIFO pointers and occupancy from push/pop/flush.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (stop) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Register the FIFO pointers, the occupancy and the post-reset ready enable.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_en_q <= 1'b1;
        end
    end

    // Write accepted samples into the FIFO storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset. The pointers and level alone define which entries are valid.
        if (push) begin
            mem_q[wr_ptr_q] <= sample_i;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: IDLE -> PRIME -> RUN, with divider and registered outputs
    // ------------------------------------------------------------------
    // Drive the playback FSM, the sample-rate divider and all vdac-facing registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            data_q     <= '0;
            enable_q   <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    count_q  <= '0;
                    data_q   <= '0;
                    enable_q <= 1'b0;
                    if (run_i) begin
                        state_q <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    count_q <= '0;
                    if (!run_i) begin
                        state_q <= ST_IDLE;
                    end else if (primed) begin
                        state_q  <= ST_RUN;
                        enable_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run_i) begin
                        state_q  <= ST_IDLE;
                        count_q  <= '0;
                        data_q   <= '0;
                        enable_q <= 1'b0;
                    end else if (tick_now) begin
                        count_q <= '0;
                        tick_q  <= 1'b1;
                        if (empty) begin
                            data_q     <= '0;
                            underrun_q <= 1'b1;
                        end else begin
                            data_q <= head;
                        end
                    end else begin
                        count_q <= count_q + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    count_q  <= '0;
                    data_q   <= '0;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_level_o = level_q;
    assign underrun_o   = underrun_q;
    assign tick_o       = tick_q;
    assign dac_data_o   = data_q;
    assign dac_enable_o = enable_q;

endmodule

// File: tb/tb_vdac_sample_driver.sv
// Testbench for vdac_sample_driver. Directed scenarios and a randomized run
// are checked against a queue-based behavioural model of the sample driver.
module tb_vdac_sample_driver;

    localparam int BW    = 6;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [BW-1:0] sample_i;
    logic          sample_valid_i;
    logic          sample_ready_o;
    logic          run_i;
    logic [DW-1:0] div_i;
    logic [LW-1:0] fifo_level_o;
    logic          underrun_o;
    logic          tick_o;
    logic [BW-1:0] dac_data_o;
    logic          dac_enable_o;

    int vectors     = 0;
    int miscompares = 0;

    vdac_sample_driver #(
        .BITWIDTH  (BW),
        .FIFO_DEPTH(DEPTH),
        .DIV_WIDTH (DW)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .sample_i      (sample_i),
        .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o),
        .run_i         (run_i),
        .div_i         (div_i),
        .fifo_level_o  (fifo_level_o),
        .underrun_o    (underrun_o),
        .tick_o        (tick_o),
        .dac_data_o    (dac_data_o),
        .dac_enable_o  (dac_enable_o)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------
    // Behavioural model: mode 0 = stopped, 1 = waiting for half-full, 2 = playing
    // ------------------------------------------------------------------
    logic [BW-1:0] m_q[$];
    int            m_mode;
    int            m_cnt;
    logic [BW-1:0] m_data;
    bit            m_en, m_tick, m_under, m_armed;

    task automatic model_reset();
        m_q.delete();
        m_mode  = 0;
        m_cnt   = 0;
        m_data  = '0;
        m_en    = 0;
        m_tick  = 0;
        m_under = 0;
        m_armed = 0;
    endtask

    function automatic bit model_ready();
        return m_armed && (m_q.size() < DEPTH);
    endfunction

    task automatic model_clock();
        bit push;
        push    = sample_valid_i && model_ready();
        m_tick  = 0;
        m_under = 0;
        case (m_mode)
            0: begin
                m_en = 0; m_data = '0; m_cnt = 0;
                if (run_i) m_mode = 1;
            end
            1: begin
                if (!run_i) m_mode = 0;
                else if (m_q.size() >= DEPTH / 2) begin
                    m_mode = 2; m_en = 1; m_cnt = 0;
                end
            end
            default: begin
                if (!run_i) begin
                    m_q.delete(); push = 0;
                    m_mode = 0; m_en = 0; m_data = '0; m_cnt = 0;
                end else if (m_cnt >= int'(div_i)) begin
                    m_tick = 1; m_cnt = 0;
                    if (m_q.size() == 0) begin
                        m_data = '0; m_under = 1;
                    end else begin
                        m_data = m_q.pop_front();
                    end
                end else begin
                    m_cnt++;
                end
            end
        endcase
        if (push) m_q.push_back(sample_i);
        m_armed = 1;
    endtask

    // Advance one clock: model and DUT see the same inputs; outputs settle by +1.
    task automatic step();
        @(posedge clk_i);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        sample_i       = '0;
        sample_valid_i = 0;
        run_i          = 0;
        div_i          = '0;
        reset_n_i      = 0;
        #2;
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1;
        step();
    endtask

    task automatic push_one(input logic [BW-1:0] s);
        sample_i       = s;
        sample_valid_i = 1;
        step();
        sample_valid_i = 0;
    endtask

    // ------------------------------------------------------------------
    // Power-on reset
    // ------------------------------------------------------------------
    task automatic test_reset();
        sample_i = '0; sample_valid_i = 0; run_i = 0; div_i = '0;
        reset_n_i = 0;
        model_reset();
        #3;
        vectors++;
        if ({dac_data_o, dac_enable_o, tick_o, underrun_o, fifo_level_o, sample_ready_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got data=%0h en=%b tick=%b und=%b lvl=%0d rdy=%b, want all 0",
                     dac_data_o, dac_enable_o, tick_o, underrun_o, fifo_level_o, sample_ready_o);
        end
        @(negedge clk_i);
        reset_n_i = 1;
        #1;
        vectors++;
        if (sample_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_pre_clock got=%b want=0", sample_ready_o);
        end
        step();
        vectors++;
        if (sample_ready_o !== 1'b1 || fifo_level_o !== '0) begin
            miscompares++;
            $display("FAIL reset_ready_post_clock got rdy=%b lvl=%0d want rdy=1 lvl=0",
                     sample_ready_o, fifo_level_o);
        end
    endtask

    // ------------------------------------------------------------------
    // Prime then play four samples at div_i=3
    // ------------------------------------------------------------------
    task automatic test_prime_play();
        logic [BW-1:0] vals [4];
        int seen;
        int last;
        vals = '{6'd5, 6'h3D, 6'd31, 6'h20};
        do_reset();
        div_i = 16'd3;
        for (int i = 0; i < 4; i++) push_one(vals[i]);
        run_i = 1;
        seen  = 0;
        last  = 0;
        for (int cyc = 0; cyc < 60 && seen < 4; cyc++) begin
            step();
            if (cyc == 0) begin
                vectors++;
                if (dac_enable_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL prime_enable_early got=%b want=0", dac_enable_o);
                end
            end
            if (tick_o) begin
                vectors++;
                if (dac_data_o !== vals[seen] || dac_enable_o !== 1'b1 || underrun_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL play_sample%0d got data=%0d en=%b und=%b want data=%0d en=1 und=0",
                             seen, $signed(dac_data_o), dac_enable_o, underrun_o, $signed(vals[seen]));
                end
                if (seen > 0) begin
                    vectors++;
                    if (cyc - last != 4) begin
                        miscompares++;
                        $display("FAIL play_spacing got=%0d want=4", cyc - last);
                    end
                end
                last = cyc;
                seen++;
            end
        end
        vectors++;
        if (seen != 4) begin
            miscompares++;
            $display("FAIL play_timeout got=%0d ticks want=4", seen);
        end
        run_i = 0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Underrun after the buffered samples are exhausted
    // ------------------------------------------------------------------
    task automatic test_underrun();
        logic [BW-1:0] vals [2];
        int seen;
        vals = '{6'd9, 6'h39};
        do_reset();
        div_i = 16'd1;
        for (int i = 0; i < 2; i++) push_one(vals[i]);
        run_i = 1;
        seen  = 0;
        for (int cyc = 0; cyc < 40 && seen < 3; cyc++) begin
            step();
            if (tick_o) begin
                vectors++;
                if (seen < 2) begin
                    if (dac_data_o !== vals[seen] || underrun_o !== 1'b0) begin
                        miscompares++;
                        $display("FAIL under_play%0d got data=%0d und=%b want data=%0d und=0",
                                 seen, $signed(dac_data_o), underrun_o, $signed(vals[seen]));
                    end
                end else if (dac_data_o !== '0 || underrun_o !== 1'b1 || dac_enable_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL under_tick got data=%0d und=%b en=%b want data=0 und=1 en=1",
                             $signed(dac_data_o), underrun_o, dac_enable_o);
                end
                seen++;
            end
        end
        vectors++;
        if (seen != 3) begin
            miscompares++;
            $display("FAIL under_timeout got=%0d ticks want=3", seen);
        end
        step();
        vectors++;
        if (underrun_o !== 1'b0 || dac_enable_o !== 1'b1) begin
            miscompares++;
            $display("FAIL under_pulse_width got und=%b en=%b want und=0 en=1", underrun_o, dac_enable_o);
        end
        run_i = 0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Full FIFO holds off a fifth sample until the first pop
    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic [BW-1:0] vals [5];
        logic [BW-1:0] got[$];
        int  t_first;
        int  t_acc;
        bit  was_ready;
        vals = '{6'd1, 6'd2, 6'h3F, 6'd17, 6'h2A};
        do_reset();
        div_i = 16'd0;
        for (int i = 0; i < 4; i++) push_one(vals[i]);
        sample_i       = vals[4];
        sample_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (sample_ready_o !== 1'b0 || fifo_level_o !== LW'(4)) begin
                miscompares++;
                $display("FAIL full_hold got rdy=%b lvl=%0d want rdy=0 lvl=4", sample_ready_o, fifo_level_o);
            end
        end
        run_i   = 1;
        t_first = -1;
        t_acc   = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            was_ready = sample_ready_o;
            step();
            if (sample_valid_i && was_ready) begin
                t_acc          = cyc;
                sample_valid_i = 0;
            end
            if (tick_o && underrun_o) break;
            if (tick_o) begin
                if (t_first < 0) t_first = cyc;
                got.push_back(dac_data_o);
            end
        end
        vectors++;
        if (t_first < 0 || t_acc != t_first + 1) begin
            miscompares++;
            $display("FAIL full_accept_cycle got=%0d want=%0d", t_acc, t_first + 1);
        end
        vectors++;
        if (got.size() != 5) begin
            miscompares++;
            $display("FAIL full_count got=%0d want=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (got[i] !== vals[i]) begin
                    miscompares++;
                    $display("FAIL full_order%0d got=%0d want=%0d", i, $signed(got[i]), $signed(vals[i]));
                end
            end
        end
        sample_valid_i = 0;
        run_i          = 0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Stop flushes the FIFO; restart plays only new samples
    // ------------------------------------------------------------------
    task automatic test_stop_flush();
        logic [BW-1:0] fresh [2];
        int  seen;
        bit  hit;
        fresh = '{6'd21, 6'h33};
        do_reset();
        div_i = 16'd10;
        for (int i = 0; i < 4; i++) push_one(6'(i + 2));
        run_i = 1;
        hit   = 0;
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            step();
            if (fifo_level_o == LW'(3)) hit = 1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL stop_wait_level3 got lvl=%0d want=3", fifo_level_o);
        end
        run_i          = 0;
        sample_i       = 6'd30;
        sample_valid_i = 1;
        step();
        sample_valid_i = 0;
        vectors++;
        if (fifo_level_o !== '0 || dac_enable_o !== 1'b0 || dac_data_o !== '0) begin
            miscompares++;
            $display("FAIL stop_flush got lvl=%0d en=%b data=%0d want 0 0 0",
                     fifo_level_o, dac_enable_o, dac_data_o);
        end
        step();
        vectors++;
        if (fifo_level_o !== '0) begin
            miscompares++;
            $display("FAIL stop_push_discard got lvl=%0d want=0", fifo_level_o);
        end
        for (int i = 0; i < 2; i++) push_one(fresh[i]);
        run_i = 1;
        seen  = 0;
        for (int cyc = 0; cyc < 80 && seen < 3; cyc++) begin
            step();
            if (tick_o) begin
                vectors++;
                if (seen < 2 && (dac_data_o !== fresh[seen] || underrun_o !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL restart_sample%0d got=%0d want=%0d", seen,
                             $signed(dac_data_o), $signed(fresh[seen]));
                end else if (seen == 2 && (underrun_o !== 1'b1 || dac_data_o !== '0)) begin
                    miscompares++;
                    $display("FAIL restart_stale got und=%b data=%0d want und=1 data=0",
                             underrun_o, dac_data_o);
                end
                seen++;
            end
        end
        vectors++;
        if (seen != 3) begin
            miscompares++;
            $display("FAIL restart_timeout got=%0d ticks want=3", seen);
        end
        run_i = 0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Lowering div_i mid-count ticks at once; div_i=0 ticks every clock
    // ------------------------------------------------------------------
    task automatic test_div_change();
        bit   entered;
        bit   want;
        div_i = 16'd100;
        do_reset();
        div_i = 16'd100;
        for (int i = 0; i < 4; i++) push_one(6'(i + 40));
        run_i   = 1;
        entered = 0;
        for (int cyc = 0; cyc < 10 && !entered; cyc++) begin
            step();
            if (dac_enable_o) entered = 1;
        end
        vectors++;
        if (!entered) begin
            miscompares++;
            $display("FAIL div_enter_timeout got en=%b want=1", dac_enable_o);
        end
        for (int i = 0; i < 50; i++) step();
        vectors++;
        if (tick_o !== 1'b0) begin
            miscompares++;
            $display("FAIL div_no_early_tick got=%b want=0", tick_o);
        end
        div_i = 16'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            want = (i == 0 || i == 3);
            vectors++;
            if (tick_o !== want) begin
                miscompares++;
                $display("FAIL div_lowered_c%0d got=%b want=%b", i, tick_o, want);
            end
        end
        div_i = 16'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (tick_o !== 1'b1 || dac_data_o !== m_data || underrun_o !== m_under) begin
                miscompares++;
                $display("FAIL div_zero_c%0d got tick=%b data=%0d und=%b want tick=1 data=%0d und=%b",
                         i, tick_o, dac_data_o, underrun_o, m_data, m_under);
            end
        end
        run_i = 0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Asynchronous reset while playing
    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        bit hit;
        do_reset();
        div_i = 16'd0;
        for (int i = 0; i < 3; i++) push_one(6'(i + 11));
        run_i = 1;
        hit   = 0;
        for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
            step();
            if (tick_o) hit = 1;
        end
        vectors++;
        if (!hit || dac_data_o === '0) begin
            miscompares++;
            $display("FAIL rstmid_setup got tick=%b data=%0d want tick=1 data!=0", tick_o, dac_data_o);
        end
        #2;
        reset_n_i = 0;
        #1;
        vectors++;
        if ({dac_data_o, dac_enable_o, tick_o, underrun_o, fifo_level_o, sample_ready_o} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs got data=%0h en=%b tick=%b und=%b lvl=%0d rdy=%b, want all 0",
                     dac_data_o, dac_enable_o, tick_o, underrun_o, fifo_level_o, sample_ready_o);
        end
        model_reset();
        run_i = 0;
        @(negedge clk_i);
        reset_n_i = 1;
        step();
        vectors++;
        if (dac_enable_o !== 1'b0 || fifo_level_o !== '0 || sample_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_after got en=%b lvl=%0d rdy=%b want en=0 lvl=0 rdy=1",
                     dac_enable_o, fifo_level_o, sample_ready_o);
        end
    endtask

    // ------------------------------------------------------------------
    // Randomized traffic, every output compared with the model each cycle
    // ------------------------------------------------------------------
    task automatic test_random();
        do_reset();
        div_i = 16'd1;
        run_i = 1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            sample_valid_i = ($urandom_range(9) < 6);
            sample_i       = BW'($urandom);
            if ($urandom_range(39) == 0) run_i = ~run_i;
            if ($urandom_range(59) == 0) div_i = DW'($urandom_range(4));
            step();
            vectors++;
            if (dac_data_o !== m_data || dac_enable_o !== m_en || tick_o !== m_tick ||
                underrun_o !== m_under || fifo_level_o !== LW'(m_q.size()) ||
                sample_ready_o !== model_ready()) begin
                miscompares++;
                $display("FAIL rnd_c%0d got d=%0h e=%b t=%b u=%b l=%0d r=%b want d=%0h e=%b t=%b u=%b l=%0d r=%b",
                         cyc, dac_data_o, dac_enable_o, tick_o, underrun_o, fifo_level_o, sample_ready_o,
                         m_data, m_en, m_tick, m_under, m_q.size(), model_ready());
            end
        end
        run_i          = 0;
        sample_valid_i = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_prime_play();
        test_underrun();
        test_backpressure();
        test_stop_flush();
        test_div_change();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
